instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
// - Builds 32-bit MIPS instruction words from op/field tuples: the inverse of the ID-stage decoder.
// - Feeds the IM loader / testbench stimulus path: each legal word leaves with its IM byte address.
// - Covers the same 34-instruction set the pipeline decodes; other op indices are rejected and counted.
// PARAMETERS
// - DEPTH      4             output FIFO entries (power of 2, >=2)
// - BASE_ADDR  32'h00003000  byte address of the first emitted word
// PORTS
// - clk        in   1   single clock, rising edge
// - reset      in   1   asynchronous, active-high; clears all state
// - in_valid   in   1   request carries a tuple
// - in_ready   out  1   block can accept this cycle
// - in_op      in   6   op index (table below)
// - in_rs/in_rt/in_rd/in_shamt  in  5 each  register/shift fields
// - in_imm     in   16  I-type immediate / branch offset (word units, raw)
// - in_target  in   26  J-type target field (raw)
// - out_valid  out  1   FIFO head valid
// - out_ready  in   1   consumer takes head this cycle
// - out_instr  out  32  encoded word at head
// - out_addr   out  32  byte address of head word
// - err_pulse  out  1   one-cycle pulse: illegal op consumed last edge
// - err_cnt    out  8   illegal ops seen, saturates at 255
// BEHAVIOUR
// - Op index: 0 ADDU,1 SUBU,2 ORI,3 LW,4 SW,5 BEQ,6 LUI,7 SLL,8 J,9 JAL,10 JR,11 ADDIU,12 BGEZ,
//   13 JALR,14 SLTI,15 LB,16 SB,17 ADD,18 ADDI,19 BLTZ,20 BGTZ,21 BLEZ,22 BNE,23 AND,24 NOR,25 OR,
//   26 SLT,27 SLLV,28 SLTU,29 SRAV,30 SRLV,31 SUB,32 XOR,33 SLTIU; 34..63 illegal.
// - R-type {6'h00,rs,rt,rd,shamt,funct}; funct: ADDU 21 SUBU 23 SLL 00 JR 08 JALR 09 ADD 20 AND 24
//   NOR 27 OR 25 SLT 2A SLLV 04 SLTU 2B SRAV 07 SRLV 06 SUB 22 XOR 26 (hex).
// - Forced zero fields: shamt=0 for all R-type except SLL; SLL rs=0; JR rt=rd=0; JALR rt=0.
// - I-type {op,rs,rt,imm}: ORI 0D LW 23 SW 2B BEQ 04 LUI 0F ADDIU 09 SLTI 0A LB 20 SB 28 ADDI 08
//   BNE 05 SLTIU 0B BGTZ 07 BLEZ 06; LUI rs=0; BGTZ/BLEZ rt=0.
// - REGIMM op 01: BGEZ rt=5'd1, BLTZ rt=5'd0 (in_rt ignored).
// - J-type {op,target}: J 02, JAL 03.
// - Accept: in_valid & in_ready at rising edge. in_ready = (count != DEPTH); no full bypass.
// - Legal accept: encode combinationally, push {word, addr_cnt} into FIFO; addr_cnt += 4 (mod 2^32).
// - Illegal accept: nothing pushed, addr_cnt unchanged; err_pulse=1 next cycle; err_cnt+1 (sat 255).
// - Latency: word accepted at edge N is at head (out_valid=1) from after edge N if FIFO was empty.
// - Pop: out_valid & out_ready at edge; head advances. out_instr/out_addr stable while out_valid & !out_ready.
// - Simultaneous push+pop: count unchanged, both pointers advance; legal when full only if in_ready=1 (it is not).
// - out_valid = (count != 0); out_instr/out_addr = 0 when empty.
// - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits, range 0..DEPTH.
// - Reset (any time, incl. mid-stream): count=0, pointers=0, addr_cnt=BASE_ADDR, err_cnt=0,
//   err_pulse=0, out_valid=0, out_instr=0, out_addr=0, in_ready=1 during and after reset.
// TESTING
// - ADDU rs=1 rt=2 rd=3 shamt=7, out_ready=1 -> out_instr=32'h00221821 (shamt zeroed), out_addr=32'h3000.
// - LUI rs=5 rt=8 imm=16'h1234 then BGEZ rs=4 imm=16'hFFFF -> 3C081234 @3000, 0481FFFF @3004.
// - JAL target=26'h0000C01, SLL rt=2 rd=4 shamt=3 rs=9 -> 0C000C01, 000220C0 (rs forced 0).
// - out_ready=0, push 5 legal ops -> in_ready drops after 4th, count=4; release -> 4 words in order, addrs 3000..300C.
// - op=40 -> no word, err_pulse 1 cycle, err_cnt=1, next legal word still @3000; 300 illegal -> err_cnt=255.
// - Reset asserted with 3 entries queued -> out_valid=0 immediately; next push emits at 3000.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes op/field tuples into 32-bit MIPS words and queues {word, byte address}
// in a small FIFO for the IM loader; illegal op indices are dropped and counted.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_pulse,
  output logic [7:0]  err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [5:0] {
    OP_ADDU = 6'd0,  OP_SUBU = 6'd1,  OP_ORI  = 6'd2,  OP_LW    = 6'd3,  OP_SW    = 6'd4,
    OP_BEQ  = 6'd5,  OP_LUI  = 6'd6,  OP_SLL  = 6'd7,  OP_J     = 6'd8,  OP_JAL   = 6'd9,
    OP_JR   = 6'd10, OP_ADDIU= 6'd11, OP_BGEZ = 6'd12, OP_JALR  = 6'd13, OP_SLTI  = 6'd14,
    OP_LB   = 6'd15, OP_SB   = 6'd16, OP_ADD  = 6'd17, OP_ADDI  = 6'd18, OP_BLTZ  = 6'd19,
    OP_BGTZ = 6'd20, OP_BLEZ = 6'd21, OP_BNE  = 6'd22, OP_AND   = 6'd23, OP_NOR   = 6'd24,
    OP_OR   = 6'd25, OP_SLT  = 6'd26, OP_SLLV = 6'd27, OP_SLTU  = 6'd28, OP_SRAV  = 6'd29,
    OP_SRLV = 6'd30, OP_SUB  = 6'd31, OP_XOR  = 6'd32, OP_SLTIU = 6'd33
  } op_e;

  logic [31:0] word;
  logic        legal;

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (in_op)
      OP_ADDU:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      OP_SUBU:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
      OP_SLL:   word = {6'h00, 5'd0,  in_rt, in_rd, in_shamt, 6'h00};
      OP_JR:    word = {6'h00, in_rs, 5'd0,  5'd0,  5'd0, 6'h08};
      OP_JALR:  word = {6'h00, in_rs, 5'd0,  in_rd, 5'd0, 6'h09};
      OP_ADD:   word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      OP_AND:   word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      OP_NOR:   word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h27};
      OP_OR:    word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      OP_SLT:   word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      OP_SLLV:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h04};
      OP_SLTU:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2B};
      OP_SRAV:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h07};
      OP_SRLV:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h06};
      OP_SUB:   word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      OP_XOR:   word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h26};
      OP_ORI:   word = {6'h0D, in_rs, in_rt, in_imm};
      OP_LW:    word = {6'h23, in_rs, in_rt, in_imm};
      OP_SW:    word = {6'h2B, in_rs, in_rt, in_imm};
      OP_BEQ:   word = {6'h04, in_rs, in_rt, in_imm};
      OP_LUI:   word = {6'h0F, 5'd0,  in_rt, in_imm};
      OP_ADDIU: word = {6'h09, in_rs, in_rt, in_imm};
      OP_SLTI:  word = {6'h0A, in_rs, in_rt, in_imm};
      OP_LB:    word = {6'h20, in_rs, in_rt, in_imm};
      OP_SB:    word = {6'h28, in_rs, in_rt, in_imm};
      OP_ADDI:  word = {6'h08, in_rs, in_rt, in_imm};
      OP_BNE:   word = {6'h05, in_rs, in_rt, in_imm};
      OP_SLTIU: word = {6'h0B, in_rs, in_rt, in_imm};
      OP_BGTZ:  word = {6'h07, in_rs, 5'd0,  in_imm};
      OP_BLEZ:  word = {6'h06, in_rs, 5'd0,  in_imm};
      // REGIMM: the rt slot selects the branch condition, not a register
      OP_BGEZ:  word = {6'h01, in_rs, 5'd1,  in_imm};
      OP_BLTZ:  word = {6'h01, in_rs, 5'd0,  in_imm};
      OP_J:     word = {6'h02, in_target};
      OP_JAL:   word = {6'h03, in_target};
      default:  legal = 1'b0;
    endcase
  end

  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [31:0]   addr_q;
  logic          err_pulse_q;
  logic [7:0]    err_cnt_q;
  logic [31:0]   word_mem_q [DEPTH];
  logic [31:0]   addr_mem_q [DEPTH];
  logic          accept, push, pop;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign pop       = out_valid & out_ready;
  assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);

  assign out_instr = out_valid ? word_mem_q[rd_q] : '0;
  assign out_addr  = out_valid ? addr_mem_q[rd_q] : '0;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem_q[wr_q] <= word;
      addr_mem_q[wr_q] <= addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      addr_q      <= BASE_ADDR;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      count_q     <= count_d;
      err_pulse_q <= accept & ~legal;
      if (push) begin
        wr_q   <= wr_q + 1'b1;
        addr_q <= addr_q + 32'd4;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (accept && !legal && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, FIFO ordering/backpressure,
// illegal-op accounting and asynchronous reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        err_pulse;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Presents one tuple for exactly one rising edge, then samples 1ns later.
  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_instr !== 32'h0 || out_addr !== 32'h0) begin bad++;
      $display("FAIL reset_out_data got=%h/%h want=0/0", out_instr, out_addr); end
    total++; if (err_cnt !== 8'd0 || err_pulse !== 1'b0) begin bad++;
      $display("FAIL reset_err got=%0d/%b want=0/0", err_cnt, err_pulse); end
  endtask

  task automatic test_rtype();
    do_reset();
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0);  // ADDU, shamt must drop
    total++; if (out_valid !== 1'b1 || out_instr !== 32'h0022_1821 || out_addr !== 32'h3000) begin bad++;
      $display("FAIL addu got=%b %h@%h want=1 00221821@3000", out_valid, out_instr, out_addr); end
    @(posedge clk); #1;
    total++; if (out_instr !== 32'h0022_1821 || out_addr !== 32'h3000) begin bad++;
      $display("FAIL addu_hold got=%h@%h want=00221821@3000", out_instr, out_addr); end
    pop_one();
    send(6'd10, 5'd5, 5'd6, 5'd7, 5'd3, 16'h0, 26'h0);  // JR
    total++; if (out_instr !== 32'h00A0_0008 || out_addr !== 32'h3004) begin bad++;
      $display("FAIL jr got=%h@%h want=00a00008@3004", out_instr, out_addr); end
    pop_one();
    send(6'd13, 5'd5, 5'd6, 5'd31, 5'd3, 16'h0, 26'h0);  // JALR
    total++; if (out_instr !== 32'h00A0_F809 || out_addr !== 32'h3008) begin bad++;
      $display("FAIL jalr got=%h@%h want=00a0f809@3008", out_instr, out_addr); end
    pop_one();
    send(6'd32, 5'd4, 5'd5, 5'd6, 5'd1, 16'h0, 26'h0);  // XOR
    total++; if (out_instr !== 32'h0085_3026) begin bad++;
      $display("FAIL xor got=%h want=00853026", out_instr); end
    pop_one();
    total++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin bad++;
      $display("FAIL empty_after_pop got=%b %h want=0 0", out_valid, out_instr); end
  endtask

  task automatic test_itype();
    do_reset();
    send(6'd6,  5'd5, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0);  // LUI
    send(6'd12, 5'd4, 5'd9, 5'd0, 5'd0, 16'hFFFF, 26'h0);  // BGEZ
    send(6'd19, 5'd3, 5'd9, 5'd0, 5'd0, 16'h0008, 26'h0);  // BLTZ
    send(6'd20, 5'd2, 5'd7, 5'd0, 5'd0, 16'h0010, 26'h0);  // BGTZ
    total++; if (out_instr !== 32'h3C08_1234 || out_addr !== 32'h3000) begin bad++;
      $display("FAIL lui got=%h@%h want=3c081234@3000", out_instr, out_addr); end
    pop_one();
    total++; if (out_instr !== 32'h0481_FFFF || out_addr !== 32'h3004) begin bad++;
      $display("FAIL bgez got=%h@%h want=0481ffff@3004", out_instr, out_addr); end
    pop_one();
    total++; if (out_instr !== 32'h0460_0008 || out_addr !== 32'h3008) begin bad++;
      $display("FAIL bltz got=%h@%h want=04600008@3008", out_instr, out_addr); end
    pop_one();
    total++; if (out_instr !== 32'h1C40_0010 || out_addr !== 32'h300C) begin bad++;
      $display("FAIL bgtz got=%h@%h want=1c400010@300c", out_instr, out_addr); end
    pop_one();
  endtask

  task automatic test_jtype();
    do_reset();
    send(6'd9, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C01);  // JAL
    send(6'd7, 5'd9, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0);        // SLL, rs forced 0
    total++; if (out_instr !== 32'h0C00_0C01 || out_addr !== 32'h3000) begin bad++;
      $display("FAIL jal got=%h@%h want=0c000c01@3000", out_instr, out_addr); end
    pop_one();
    total++; if (out_instr !== 32'h0002_20C0 || out_addr !== 32'h3004) begin bad++;
      $display("FAIL sll got=%h@%h want=000220c0@3004", out_instr, out_addr); end
    pop_one();
  endtask

  task automatic test_full();
    logic [31:0] exp_w;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      total++; if (in_ready !== (i < 4)) begin bad++;
        $display("FAIL full_in_ready[%0d] got=%b want=%b", i, in_ready, (i < 4)); end
      send(6'd2, 5'd0, 5'(i), 5'd0, 5'd0, 16'(i), 26'h0);  // ORI
    end
    for (int i = 0; i < 4; i++) begin
      exp_w = 32'h3400_0000 | (32'(i) << 16) | 32'(i);
      total++; if (out_valid !== 1'b1 || out_instr !== exp_w || out_addr !== 32'h3000 + 32'(4*i)) begin bad++;
        $display("FAIL full_drain[%0d] got=%b %h@%h want=1 %h@%h", i, out_valid, out_instr, out_addr,
                 exp_w, 32'h3000 + 32'(4*i)); end
      pop_one();
    end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
      $display("FAIL full_empty got=%b/%b want=0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_op = 6'd11; in_rs = 5'd1; in_rt = 5'd2; in_imm = 16'(i); in_valid = 1'b1;  // ADDIU
      @(posedge clk); #1;
      exp_w = 32'h2422_0000 | 32'(i);
      total++; if (out_valid !== 1'b1 || out_instr !== exp_w || out_addr !== 32'h3000 + 32'(4*i)) begin bad++;
        $display("FAIL b2b[%0d] got=%b %h@%h want=1 %h@%h", i, out_valid, out_instr, out_addr,
                 exp_w, 32'h3000 + 32'(4*i)); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    send(6'd40, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    total++; if (out_valid !== 1'b0 || err_pulse !== 1'b1 || err_cnt !== 8'd1) begin bad++;
      $display("FAIL illegal40 got=%b/%b/%0d want=0/1/1", out_valid, err_pulse, err_cnt); end
    @(posedge clk); #1;
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL err_pulse_width got=%b want=0", err_pulse); end
    send(6'd34, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    total++; if (err_cnt !== 8'd2 || out_valid !== 1'b0) begin bad++;
      $display("FAIL illegal34 got=%0d/%b want=2/0", err_cnt, out_valid); end
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0);
    total++; if (out_instr !== 32'h0022_1821 || out_addr !== 32'h3000) begin bad++;
      $display("FAIL after_illegal got=%h@%h want=00221821@3000", out_instr, out_addr); end
    pop_one();
    in_op = 6'd63; in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1 in_valid = 1'b0;
    total++; if (err_cnt !== 8'd255 || out_valid !== 1'b0) begin bad++;
      $display("FAIL err_sat got=%0d/%b want=255/0", err_cnt, out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) send(6'd25, 5'd1, 5'd2, 5'(i), 5'd0, 16'h0, 26'h0);  // OR
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_prefill got=%b want=1", out_valid); end
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_addr !== 32'h0) begin bad++;
      $display("FAIL mid_reset got=%b/%b %h@%h want=0/1 0@0", out_valid, in_ready, out_instr, out_addr); end
    @(posedge clk); #1 reset = 1'b0;
    send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    total++; if (out_instr !== 32'h0022_1821 || out_addr !== 32'h3000) begin bad++;
      $display("FAIL mid_after got=%h@%h want=00221821@3000", out_instr, out_addr); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_jtype();
    test_full();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
